dsp_mode_reg_pipe: RTL

Parametrised pipeline register for DSP slice control words (ALUMODE, OPMODE, INMODE, CARRYINSEL).
- Generalises the single-stage ALUMODE register: configurable width, depth 0..3 and optional double-buffered shadow/commit front stage.
- Adds a change-detect pulse and a pipeline-fill indicator.
- Sits between the slice control-input pins and the ALU/multiplexer decode logic.
- CE is a functional enable on flops; no gated clock.

---
 rtl/dsp_slice_pkg.sv | 37 +++
 rtl/dsp_ctrl_stage.sv | 26 ++
 rtl/dsp_mode_reg_pipe.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dsp_slice_pkg.sv
// Shared widths, reset defaults and types for DSP slice control-word registers.
package dsp_slice_pkg;

    localparam int unsigned ALUMODE_W    = 4;
    localparam int unsigned OPMODE_W     = 9;
    localparam int unsigned INMODE_W     = 5;
    localparam int unsigned CARRYINSEL_W = 3;

    localparam int unsigned DEPTH_MAX    = 3;
    localparam int unsigned WIDTH_MAX    = 16;

    localparam logic [ALUMODE_W-1:0]    ALUMODE_RST    = ALUMODE_W'(0);
    localparam logic [OPMODE_W-1:0]     OPMODE_RST     = OPMODE_W'(0);
    localparam logic [INMODE_W-1:0]     INMODE_RST     = INMODE_W'(0);
    localparam logic [CARRYINSEL_W-1:0] CARRYINSEL_RST = CARRYINSEL_W'(0);

    // Full slice control bundle as seen at the slice pins.
    typedef struct packed {
        logic [ALUMODE_W-1:0]    alumode;
        logic [OPMODE_W-1:0]     opmode;
        logic [INMODE_W-1:0]     inmode;
        logic [CARRYINSEL_W-1:0] carryinsel;
    } dsp_ctrl_t;

    localparam dsp_ctrl_t DSP_CTRL_RST = '{
        alumode:    ALUMODE_RST,
        opmode:     OPMODE_RST,
        inmode:     INMODE_RST,
        carryinsel: CARRYINSEL_RST
    };

    // Fill counter must hold 0..depth inclusive.
    function automatic int unsigned fill_cnt_w(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dsp_ctrl_stage.sv
// One control-word flop: async reset, clock enable, enable-qualified sync reset.
module dsp_ctrl_stage #(
    parameter int unsigned            WIDTH   = 4,
    parameter logic [WIDTH-1:0]       RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             srst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (ce) begin
            if (srst) begin
                q <= RST_VAL;
            end else begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/dsp_mode_reg_pipe.sv
// Configurable-depth pipeline register for DSP slice control words with optional
// shadow/commit front stage, change-detect pulse and pipeline-fill flag.
module dsp_mode_reg_pipe
    import dsp_slice_pkg::*;
#(
    parameter int unsigned      WIDTH      = 4,
    parameter int unsigned      DEPTH      = 1,
    parameter logic [WIDTH-1:0] RST_VAL    = '0,
    parameter bit               DOUBLE_BUF = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             SRST,
    input  logic [WIDTH-1:0] MODE_IN,
    input  logic             COMMIT,
    output logic [WIDTH-1:0] MODE_OUT,
    output logic             MODE_CHG,
    output logic             FILLED
);

    if (WIDTH == 0 || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("dsp_mode_reg_pipe: WIDTH must be 1..%0d", WIDTH_MAX);
    end
    if (DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("dsp_mode_reg_pipe: DEPTH must be 0..%0d", DEPTH_MAX);
    end
    if (DOUBLE_BUF && DEPTH == 0) begin : g_bad_dbuf
        $error("dsp_mode_reg_pipe: DOUBLE_BUF requires DEPTH >= 1");
    end

    if (DEPTH == 0) begin : g_bypass
        // Pure wire path; clock and control pins have no function here.
        logic unused_ctrl;
        assign unused_ctrl = ^{CLK, RST, CE, SRST, COMMIT};

        assign MODE_OUT = MODE_IN;
        assign MODE_CHG = 1'b0;
        assign FILLED   = 1'b1;
    end else begin : g_pipe
        localparam int unsigned CNT_W = fill_cnt_w(DEPTH);

        logic [WIDTH-1:0] stage_d [1:DEPTH];
        logic [WIDTH-1:0] stage_q [1:DEPTH];

        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             chg_q;
        logic             chg_d;
        logic             filled_q;

        if (DOUBLE_BUF) begin : g_dbuf
            logic [WIDTH-1:0] shadow_q;

            dsp_ctrl_stage #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_VAL)
            ) u_shadow (
                .clk  (CLK),
                .rst  (RST),
                .ce   (CE),
                .srst (SRST),
                .d    (MODE_IN),
                .q    (shadow_q)
            );

            // Stage 1 recirculates unless a commit moves the pre-edge shadow in.
            assign stage_d[1] = COMMIT ? shadow_q : stage_q[1];
        end else begin : g_sbuf
            logic unused_commit;
            assign unused_commit = COMMIT;

            assign stage_d[1] = MODE_IN;
        end

        for (genvar k = 2; k <= DEPTH; k++) begin : g_shift
            assign stage_d[k] = stage_q[k-1];
        end

        for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
            dsp_ctrl_stage #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_VAL)
            ) u_stage (
                .clk  (CLK),
                .rst  (RST),
                .ce   (CE),
                .srst (SRST),
                .d    (stage_d[k]),
                .q    (stage_q[k])
            );
        end

        // Change detect looks one edge ahead so the pulse lines up with the new output.
        always_comb begin
            cnt_d = cnt_q;
            chg_d = 1'b0;
            if (CE) begin
                if (SRST) begin
                    cnt_d = '0;
                end else begin
                    chg_d = (stage_d[DEPTH] != stage_q[DEPTH]);
                    if (cnt_q != CNT_W'(DEPTH)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                cnt_q    <= '0;
                chg_q    <= 1'b0;
                filled_q <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                chg_q    <= chg_d;
                filled_q <= (cnt_d == CNT_W'(DEPTH));
            end
        end

        assign MODE_OUT = stage_q[DEPTH];
        assign MODE_CHG = chg_q;
        assign FILLED   = filled_q;
    end

endmodule
